// File: rtl/player_draw_pkg.sv
// player_draw_pkg -- definitions shared by player_draw and block_scan.
//   SCREEN_W / SCREEN_H : visible VGA area; pixels outside it are never plotted.
//   COLOUR_W            : width of a pixel colour.
//   CNT_W               : width of a block column/row counter (blocks are up to 16 px).
//   state_t             : update sequencer states.
//   on_screen()         : true when an unwrapped pixel coordinate lies on screen.
package player_draw_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

  function automatic logic on_screen(input logic [8:0] x, input logic [7:0] y);
    return (x < 9'(SCREEN_W)) && (y < 8'(SCREEN_H));
  endfunction
endpackage

// File: rtl/player_draw_block_scan.sv
// block_scan -- row-major pixel counter over a BLOCK_W x BLOCK_H block.
//   clock, resetn : rising-edge clock, synchronous active-low reset
//   start         : restart the scan at (0,0)
//   enable        : advance one pixel (column fastest, wraps at block end)
//   col_nxt/row_nxt : counter value after this edge, so the parent can
//                   register pixel outputs in the same cycle the counter moves
//   last          : current count is the final pixel (BLOCK_W-1, BLOCK_H-1)
module block_scan
  import player_draw_pkg::*;
#(
  parameter int BLOCK_W = 10,
  parameter int BLOCK_H = 10
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             enable,
  output logic [CNT_W-1:0] col_nxt,
  output logic [CNT_W-1:0] row_nxt,
  output logic             last
);
  logic [CNT_W-1:0] col, row;
  logic             col_end, row_end;

  assign col_end = (col == CNT_W'(BLOCK_W - 1));
  assign row_end = (row == CNT_W'(BLOCK_H - 1));
  assign last    = col_end && row_end;

  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (start) begin
      col_nxt = '0;
      row_nxt = '0;
    end else if (enable) begin
      if (col_end) begin
        col_nxt = '0;
        row_nxt = row_end ? '0 : row + 1'b1;
      end else begin
        col_nxt = col + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end
endmodule

// File: rtl/player_draw.sv
// player_draw -- erases a block at its old position and redraws it at a new one.
//   clock, resetn          : rising-edge clock, synchronous active-low reset
//   go                     : start an update (only honoured in IDLE)
//   x_in, y_in, colour_in  : new block top-left and colour, latched on go
//   vga_x, vga_y, vga_colour, plot : registered pixel write to the VGA adapter
//   busy                   : high for every erase/draw pixel cycle
//   done                   : one-cycle pulse after the last drawn pixel
// Build option: define PLAYER_DRAW_ERASE_EN to erase the previous block
// position (in BG_COLOUR) before drawing; otherwise every update only draws.
module player_draw
  import player_draw_pkg::*;
#(
  parameter int                  BLOCK_W   = 10,
  parameter int                  BLOCK_H   = 10,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                go,
  input  logic [7:0]          x_in,
  input  logic [6:0]          y_in,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);
  state_t              state, state_nxt;
  logic [7:0]          new_x, new_x_d;
  logic [6:0]          new_y, new_y_d;
  logic [COLOUR_W-1:0] new_c, new_c_d;
`ifdef PLAYER_DRAW_ERASE_EN
  logic [7:0]          old_x;
  logic [6:0]          old_y;
  logic                old_vld;
`endif
  logic                scan_start, scan_en, last;
  logic [CNT_W-1:0]    col_nxt, row_nxt;
  logic [7:0]          base_x;
  logic [6:0]          base_y;
  logic [8:0]          px;
  logic [7:0]          py;
  logic [7:0]          x_d;
  logic [6:0]          y_d;
  logic [COLOUR_W-1:0] c_d;
  logic                plot_d, busy_d, done_d;

  block_scan #(.BLOCK_W(BLOCK_W), .BLOCK_H(BLOCK_H)) u_scan (
    .clock   (clock),
    .resetn  (resetn),
    .start   (scan_start),
    .enable  (scan_en),
    .col_nxt (col_nxt),
    .row_nxt (row_nxt),
    .last    (last)
  );

  // Next state, plus scan control derived from the transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go) begin
`ifdef PLAYER_DRAW_ERASE_EN
        state_nxt = old_vld ? S_ERASE : S_DRAW;
`else
        state_nxt = S_DRAW;
`endif
      end
      S_ERASE: if (last) state_nxt = S_DRAW;
      S_DRAW:  if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    scan_start = (state_nxt != state) && (state_nxt == S_ERASE || state_nxt == S_DRAW);
    scan_en    = (state_nxt == state) && (state == S_ERASE || state == S_DRAW);
  end

  // Output D-values: pixel outputs are registered from the *next* state and
  // counter so the first pixel of a phase appears the cycle after entry.
  always_comb begin
    // In IDLE the latch is loading this edge, so draw from the inputs directly.
    new_x_d = new_x;
    new_y_d = new_y;
    new_c_d = new_c;
    if (state == S_IDLE && go) begin
      new_x_d = x_in;
      new_y_d = y_in;
      new_c_d = colour_in;
    end
    base_x = new_x_d;
    base_y = new_y_d;
    c_d    = new_c_d;
`ifdef PLAYER_DRAW_ERASE_EN
    if (state_nxt == S_ERASE) begin
      base_x = old_x;
      base_y = old_y;
    end
`endif
    if (state_nxt == S_ERASE) c_d = BG_COLOUR;
    // Widened sums: off-screen pixels are suppressed rather than wrapped.
    px     = {1'b0, base_x} + 9'(col_nxt);
    py     = {1'b0, base_y} + 8'(row_nxt);
    busy_d = (state_nxt == S_ERASE) || (state_nxt == S_DRAW);
    plot_d = busy_d && on_screen(px, py);
    done_d = (state_nxt == S_DONE);
    x_d    = busy_d ? px[7:0] : '0;
    y_d    = busy_d ? py[6:0] : '0;
    if (!busy_d) c_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      new_x      <= '0;
      new_y      <= '0;
      new_c      <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef PLAYER_DRAW_ERASE_EN
      old_x      <= '0;
      old_y      <= '0;
      old_vld    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      new_x      <= new_x_d;
      new_y      <= new_y_d;
      new_c      <= new_c_d;
      vga_x      <= x_d;
      vga_y      <= y_d;
      vga_colour <= c_d;
      plot       <= plot_d;
      busy       <= busy_d;
      done       <= done_d;
`ifdef PLAYER_DRAW_ERASE_EN
      if (state == S_DONE) begin
        old_x   <= new_x;
        old_y   <= new_y;
        old_vld <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_player_draw.sv
// tb_player_draw -- self-checking bench for player_draw: a table of directed
// updates with expected done cycle / plot count, randomized updates, and a
// per-cycle reference model of the expected pixel stream.
module tb_player_draw;
  localparam int BW = 10, BH = 10, NPIX = BW * BH;
`ifdef PLAYER_DRAW_ERASE_EN
  localparam bit ERASE_EN = 1'b1;
`else
  localparam bit ERASE_EN = 1'b0;
`endif

  logic       clock = 1'b0, resetn = 1'b0, go = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy, done;

  player_draw #(.BLOCK_W(BW), .BLOCK_H(BH), .BG_COLOUR(3'b000)) dut (
    .clock(clock), .resetn(resetn), .go(go), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {bit busy; bit done; bit plot; int x; int y; bit [2:0] col;} cyc_t;
  typedef struct {int x; int y; int c; int glitch; int rst_at; int exp_done; int exp_plots;} tv_t;

  cyc_t exp_q[$];
  int   n_chk = 0, n_err = 0;
  bit   m_old_vld = 0;
  int   m_old_x = 0, m_old_y = 0;
  int   m_exp_plots = 0;

  task automatic check(input string name, input bit ok, input string detail);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Expected output stream for one update, one entry per cycle after go.
  task automatic add_block(input int ox, input int oy, input bit [2:0] c);
    cyc_t e;
    for (int r = 0; r < BH; r++)
      for (int k = 0; k < BW; k++) begin
        e.busy = 1; e.done = 0; e.x = ox + k; e.y = oy + r; e.col = c;
        e.plot = (e.x < 160) && (e.y < 120);
        if (e.plot) m_exp_plots++;
        exp_q.push_back(e);
      end
  endtask

  task automatic build(input int x, input int y, input int c);
    cyc_t e;
    exp_q.delete();
    m_exp_plots = 0;
    if (ERASE_EN && m_old_vld) add_block(m_old_x, m_old_y, 3'b000);
    add_block(x, y, 3'(c));
    e.busy = 0; e.done = 1; e.plot = 0; e.x = 0; e.y = 0; e.col = 0;
    exp_q.push_back(e);
    e.done = 0;
    exp_q.push_back(e);
  endtask

  task automatic run_update(input int x, input int y, input int c, input int glitch,
                            input int rst_at, output int done_cyc, output int nplot);
    cyc_t e;
    bit   ok;
    int   len;
    build(x, y, c);
    len = exp_q.size();
    done_cyc = -1;
    nplot = 0;
    @(negedge clock);
    go = 1; x_in = 8'(x); y_in = 7'(y); colour_in = 3'(c);
    @(negedge clock);
    for (int k = 1; k <= len; k++) begin
      if (k > 1) @(negedge clock);
      if (k == 1) begin
        x_in = 8'($urandom); y_in = 7'($urandom); colour_in = 3'($urandom);
      end
      go = (k == glitch);
      e = exp_q[k-1];
      ok = (busy == e.busy) && (done == e.done) && (plot == e.plot) &&
           (!e.plot || (vga_x == 8'(e.x) && vga_y == 7'(e.y) && vga_colour == e.col));
      check("pixel", ok, $sformatf(
        "cyc=%0d got busy=%0b done=%0b plot=%0b x=%0d y=%0d c=%0d want busy=%0b done=%0b plot=%0b x=%0d y=%0d c=%0d",
        k, busy, done, plot, vga_x, vga_y, vga_colour, e.busy, e.done, e.plot, e.x, e.y, e.col));
      if (done) done_cyc = k;
      if (plot) nplot++;
      if (k == rst_at) begin
        resetn = 0;
        @(negedge clock);
        check("abort_reset", plot == 0 && busy == 0 && done == 0 && vga_x == 0 &&
              vga_y == 0 && vga_colour == 0,
              $sformatf("got plot=%0b busy=%0b done=%0b x=%0d y=%0d c=%0d want all 0",
                        plot, busy, done, vga_x, vga_y, vga_colour));
        resetn = 1;
        m_old_vld = 0;
        return;
      end
    end
    go = 0;
    m_old_vld = 1; m_old_x = x; m_old_y = y;
  endtask

  initial begin
    tv_t tv[7];
    int  dc, np, len, gl, ra, x, y, c;
    tv[0] = '{0,   0,   4, 0,  0, 101, 100};
    tv[1] = '{118, 10,  3, 0,  0, ERASE_EN ? 201 : 101, ERASE_EN ? 200 : 100};
    tv[2] = '{155, 115, 5, 0,  0, ERASE_EN ? 201 : 101, ERASE_EN ? 125 : 25};
    tv[3] = '{155, 115, 6, 0,  0, ERASE_EN ? 201 : 101, ERASE_EN ? 50 : 25};
    tv[4] = '{20,  30,  2, 50, 0, ERASE_EN ? 201 : 101, ERASE_EN ? 125 : 100};
    tv[5] = '{50,  50,  7, 0,  ERASE_EN ? NPIX + 40 : 40, -1, -1};
    tv[6] = '{0,   0,   1, 0,  0, 101, 100};

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_state", plot == 0 && busy == 0 && done == 0 && vga_x == 0 &&
          vga_y == 0 && vga_colour == 0,
          $sformatf("got plot=%0b busy=%0b done=%0b x=%0d y=%0d c=%0d want all 0",
                    plot, busy, done, vga_x, vga_y, vga_colour));
    resetn = 1;

    for (int i = 0; i < 7; i++) begin
      run_update(tv[i].x, tv[i].y, tv[i].c, tv[i].glitch, tv[i].rst_at, dc, np);
      if (tv[i].rst_at == 0) begin
        check($sformatf("tv%0d_done_cycle", i), dc == tv[i].exp_done,
              $sformatf("got %0d want %0d", dc, tv[i].exp_done));
        check($sformatf("tv%0d_plot_count", i), np == tv[i].exp_plots,
              $sformatf("got %0d want %0d", np, tv[i].exp_plots));
      end
    end

    for (int i = 0; i < 12; i++) begin
      x  = int'($urandom_range(0, 200));
      y  = int'($urandom_range(0, 127));
      c  = int'($urandom_range(0, 7));
      len = (ERASE_EN && m_old_vld) ? 2 * NPIX + 2 : NPIX + 2;
      gl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len - 1)) : 0;
      ra = (gl == 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, len - 2)) : 0;
      run_update(x, y, c, gl, ra, dc, np);
      if (ra == 0) begin
        check("rand_done_cycle", dc == len - 1, $sformatf("got %0d want %0d", dc, len - 1));
        check("rand_plot_count", np == m_exp_plots,
              $sformatf("got %0d want %0d", np, m_exp_plots));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/player_draw.md
PLAYER_DRAW -- requirements
Module: player_draw

Interface
REQ-001 Parameter BLOCK_W, default 10: block width in pixels (1..16).
REQ-002 Parameter BLOCK_H, default 10: block height in pixels (1..16).
REQ-003 Parameter BG_COLOUR, default 3'b000: colour used to erase.
REQ-004 clock  in  1  single system clock; all logic rising-edge.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 go  in  1  start request; sampled only in IDLE.
REQ-007 x_in  in  8  new block top-left x (from downstate x).
REQ-008 y_in  in  7  new block top-left y (from downstate y).
REQ-009 colour_in  in  3  block colour.
REQ-010 vga_x  out  8  pixel x to VGA adapter.
REQ-011 vga_y  out  7  pixel y to VGA adapter.
REQ-012 vga_colour  out  3  pixel colour.
REQ-013 plot  out  1  write-enable for the current pixel.
REQ-014 busy  out  1  high while a frame update is in progress.
REQ-015 done  out  1  one-cycle pulse when an update finishes.

Function
REQ-016 FSM states IDLE, ERASE, DRAW, DONE; all outputs registered.
REQ-017 IDLE & go=1 at edge N: latch x_in, y_in, colour_in; go to ERASE if an old position is valid, else DRAW.
REQ-018 Pixels scanned row-major: column counter fastest, 0..BLOCK_W-1, then row 0..BLOCK_H-1; one pixel per cycle.
REQ-019 ERASE emits old position + (col,row) with vga_colour=BG_COLOUR; DRAW emits latched new position + (col,row) with latched colour.
REQ-020 First pixel of a phase visible in cycle after entering it; ERASE occupies cycles N+1..N+BLOCK_W*BLOCK_H, DRAW the next BLOCK_W*BLOCK_H cycles.
REQ-021 After last DRAW pixel: DONE for one cycle, done=1, busy=0, plot=0; then IDLE; old position := latched new position, old-valid := 1.
REQ-022 busy=1 in every ERASE and DRAW cycle, 0 otherwise.
REQ-023 Coordinate sums use 9-bit (x) / 8-bit (y) arithmetic; pixel with x>=160 or y>=120 has plot=0 but still consumes its cycle (no wrap-around drawn).
REQ-024 go while busy or in DONE is ignored; inputs changing mid-update have no effect.
REQ-025 Same old and new position still performs full erase then draw.

Reset
REQ-026 resetn=0 at a clock edge: state IDLE, counters 0, old-valid 0, vga_x=0, vga_y=0, vga_colour=0, plot=0, busy=0, done=0.
REQ-027 Reset mid-update aborts immediately; no further pixels plotted; next go is treated as first draw (no erase).

Configuration
REQ-028 Macro PLAYER_DRAW_ERASE_EN defined: ERASE phase behaves as above.
REQ-029 Macro undefined: ERASE state, old-position registers and old-valid omitted; go always enters DRAW; done at N+BLOCK_W*BLOCK_H+1.

Structure
REQ-030 Shared package holds SCREEN_W=160, SCREEN_H=120, colour width 3, state enum type.
REQ-031 One sub-module block_scan: col/row counter with start, enable, last-pixel flag, parameterised by BLOCK_W/BLOCK_H.

Verification
REQ-032 Reset, go=1, x_in=0, y_in=0, colour 3'b100 -> no erase; 100 plots (0..9,0..9) colour 100 in cycles 1..100; done in cycle 101.
REQ-033 Then go with x_in=118, y_in=10 -> 100 erase plots at (0..9,0..9) colour 000, 100 draw plots at (118..127,10..19); done at cycle 201.
REQ-034 Position x_in=155, y_in=115 -> plot=0 for x>=160 or y>=120 (75 suppressed, 25 plotted), total timing unchanged.
REQ-035 go pulsed at cycle 50 of an update -> ignored; no restart, done at the original cycle.
REQ-036 resetn=0 during DRAW pixel 40 -> plot=0 next cycle; subsequent go performs no erase.
REQ-037 Build without PLAYER_DRAW_ERASE_EN, two updates -> second update has no BG_COLOUR plots; done at cycle 101.
